// File: rtl/dcpu_bus_pkg.sv
// dcpu_bus_pkg: shared encodings and widths for the dcpu memory bus RAM slave
package dcpu_bus_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 32;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;
   localparam int LANE_LO = 0;
   localparam int LANE_HI = 1;
   localparam logic [DATA_W-1:0] MISS_DATA = 16'hFFFF;
   typedef struct packed {
      logic              we;
      logic              hit;
      logic [1:0]        stb;
      logic [DATA_W-1:0] dat;
   } req_t;
endpackage

// File: rtl/dcpu_bus_ram_if.sv
// dcpu_bus_ram_if: dcpu memory bus signals seen from CPU (master) and memory (slave)
interface dcpu_bus_ram_if;
   import dcpu_bus_pkg::*;
   logic              cyc;
   logic [1:0]        stb;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdat;
   logic [DATA_W-1:0] rdat;
   logic              ack;
   modport master (output cyc, stb, we, addr, wdat, input rdat, ack);
   modport slave  (input cyc, stb, we, addr, wdat, output rdat, ack);
endinterface

// File: rtl/dcpu_ram_1rw.sv
// dcpu_ram_1rw: single-port 16-bit RAM with byte enables and registered read
module dcpu_ram_1rw
   import dcpu_bus_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              i_clk,
   input  logic              i_en,
   input  logic [1:0]        i_be,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_dat,
   output logic [DATA_W-1:0] o_dat
);
   logic [DATA_W-1:0] mem [2**AW];
   logic [DATA_W-1:0] rdat_q;

   // enabled lanes are written; the read port returns the pre-write word
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_be[LANE_LO]) mem[i_addr][7:0] <= i_dat[7:0];
         if (i_be[LANE_HI]) mem[i_addr][15:8] <= i_dat[15:8];
         rdat_q <= mem[i_addr];
      end
   end

   assign o_dat = rdat_q;
endmodule

// File: rtl/dcpu_bus_ram.sv
// dcpu_bus_ram: dcpu bus slave serving a RAM window with wait states and single-cycle acks
module dcpu_bus_ram
   import dcpu_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          ADDR_WIDTH  = 10,
   parameter int          WAIT_STATES = 1
) (
   input logic           i_clk,
   input logic           i_reset,
   dcpu_bus_ram_if.slave bus
);
   // window bounds in 33 bits so a window at the top of the space does not wrap
   localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << (ADDR_WIDTH + 1));

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d, ram_idx;
   req_t                  req_q, req_d, live, cur;
   logic                  req, hit, in_idle, commit, ack;
   logic [1:0]            ram_be;
   logic [DATA_W-1:0]     ram_dat;

   assign req     = bus.cyc & (bus.stb != 2'b00);
   assign hit     = ({1'b0, bus.addr} >= WIN_LO) && ({1'b0, bus.addr} < WIN_HI);
   assign live    = '{we: bus.we, hit: hit, stb: bus.stb, dat: bus.wdat};
   assign in_idle = state_q == ST_IDLE;
   // with zero wait states the RAM is accessed on the capture edge, so use live fields
   assign cur     = in_idle ? live : req_q;
   assign ram_idx = in_idle ? bus.addr[ADDR_WIDTH:1] : idx_q;
   assign ram_be  = (cur.we & cur.hit) ? cur.stb : 2'b00;

   // next-state, wait counter and request capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      req_d   = req_q;
      commit  = 1'b0;
      if (state_q == ST_IDLE) begin
         if (req) begin
            idx_d   = bus.addr[ADDR_WIDTH:1];
            req_d   = live;
            state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
            cnt_d   = 4'(WAIT_STATES);
            commit  = WAIT_STATES == 0;
         end
      end else if (state_q == ST_WAIT) begin
         state_d = !bus.cyc ? ST_IDLE : (cnt_q == 4'd1) ? ST_ACK : ST_WAIT;
         cnt_d   = (!bus.cyc || cnt_q == 4'd1) ? 4'd0 : cnt_q - 4'd1;
         commit  = bus.cyc && cnt_q == 4'd1;
      end else begin
         state_d = ST_IDLE;
      end
   end

   // control state with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // latched request fields need no reset
   always_ff @(posedge i_clk) begin
      idx_q <= idx_d;
      req_q <= req_d;
   end

   dcpu_ram_1rw #(.AW(ADDR_WIDTH)) u_ram (
      .i_clk  (i_clk),
      .i_en   (commit & ~i_reset),
      .i_be   (ram_be),
      .i_addr (ram_idx),
      .i_dat  (cur.dat),
      .o_dat  (ram_dat)
   );

   assign ack      = state_q == ST_ACK;
   assign bus.ack  = ack;
   assign bus.rdat = (ack && !req_q.we) ? (req_q.hit ? ram_dat : MISS_DATA) : '0;
endmodule

// File: tb/tb_dcpu_bus_ram.sv
// tb_dcpu_bus_ram: scoreboard bench for two dcpu_bus_ram instances (1 and 3 wait states)
module tb_dcpu_bus_ram;
   import dcpu_bus_pkg::*;

   typedef struct {
      logic [15:0] d;
      int          t;
   } exp_t;

   logic clk = 1'b0;
   logic rst1 = 1'b1;
   logic rst3 = 1'b1;
   int   cyc_n = 0;
   int   compared = 0;
   int   mismatched = 0;
   exp_t q1[$];
   exp_t q3[$];

   dcpu_bus_ram_if b1 ();
   dcpu_bus_ram_if b3 ();

   dcpu_bus_ram #(.BASE_ADDR(32'h0000_0000), .ADDR_WIDTH(10), .WAIT_STATES(1)) u1 (
      .i_clk(clk), .i_reset(rst1), .bus(b1.slave));
   dcpu_bus_ram #(.BASE_ADDR(32'hFFFF_F800), .ADDR_WIDTH(10), .WAIT_STATES(3)) u3 (
      .i_clk(clk), .i_reset(rst3), .bus(b3.slave));

   always #5 clk = ~clk;

   // count rising edges so ack timing can be checked against issue time
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // monitor: every ack pops one expectation; outside acks the data bus must be 0
   always @(negedge clk) begin
      exp_t e;
      compared++;
      if (b1.ack) begin
         if (q1.size() == 0) begin
            mismatched++;
            $display("FAIL ack1_spurious: ack with data %h at cycle %0d, required no ack", b1.rdat, cyc_n);
         end else begin
            e = q1.pop_front();
            if (b1.rdat !== e.d || cyc_n != e.t) begin
               mismatched++;
               $display("FAIL ack1: data %h at cycle %0d, required %h at cycle %0d", b1.rdat, cyc_n, e.d, e.t);
            end
         end
      end else if (b1.rdat !== 16'h0) begin
         mismatched++;
         $display("FAIL idle1_dat: data %h without ack, required 0000", b1.rdat);
      end
      compared++;
      if (b3.ack) begin
         if (q3.size() == 0) begin
            mismatched++;
            $display("FAIL ack3_spurious: ack with data %h at cycle %0d, required no ack", b3.rdat, cyc_n);
         end else begin
            e = q3.pop_front();
            if (b3.rdat !== e.d || cyc_n != e.t) begin
               mismatched++;
               $display("FAIL ack3: data %h at cycle %0d, required %h at cycle %0d", b3.rdat, cyc_n, e.d, e.t);
            end
         end
      end else if (b3.rdat !== 16'h0) begin
         mismatched++;
         $display("FAIL idle3_dat: data %h without ack, required 0000", b3.rdat);
      end
   end

   task automatic drive(input bit sel, input logic c, input logic [1:0] s, input logic w,
                        input logic [31:0] a, input logic [15:0] d);
      if (sel) begin
         b3.cyc = c; b3.stb = s; b3.we = w; b3.addr = a; b3.wdat = d;
      end else begin
         b1.cyc = c; b1.stb = s; b1.we = w; b1.addr = a; b1.wdat = d;
      end
   endtask

   task automatic wait_ack(input bit sel, input string n);
      bit seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         seen = sel ? b3.ack : b1.ack;
      end
      if (!seen) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: no ack within 30 cycles, required one", n);
      end
   endtask

   task automatic push(input bit sel, input logic [15:0] d, input int t);
      exp_t e;
      e.d = d;
      e.t = t;
      if (sel) q3.push_back(e); else q1.push_back(e);
   endtask

   // one complete access; ack expected in the cycle after edge issue+1+wait_states
   task automatic acc(input bit sel, input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic [15:0] d, input logic [15:0] x, input string n);
      @(negedge clk);
      drive(sel, 1'b1, s, w, a, d);
      push(sel, w ? 16'h0 : x, cyc_n + 1 + (sel ? 3 : 1));
      wait_ack(sel, n);
      drive(sel, 1'b0, 2'b00, 1'b0, 32'h0, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int c;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 16'h0);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 16'h0);
      repeat (2) @(negedge clk);
      rst1 = 1'b0;
      rst3 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         compared++;
         if (b1.ack !== 1'b0 || b1.rdat !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_idle: ack %b data %h, required 0 0000", b1.ack, b1.rdat);
         end
      end
      // basic write/read with one wait state
      acc(1'b0, 1'b1, 32'h0000_0004, 2'b11, 16'hBEEF, 16'h0,    "wr_beef");
      acc(1'b0, 1'b0, 32'h0000_0004, 2'b11, 16'h0,    16'hBEEF, "rd_beef");
      // byte lanes
      acc(1'b0, 1'b1, 32'h0000_0010, 2'b11, 16'h1234, 16'h0,    "wr_1234");
      acc(1'b0, 1'b1, 32'h0000_0010, 2'b01, 16'hAB55, 16'h0,    "wr_lo");
      acc(1'b0, 1'b0, 32'h0000_0010, 2'b10, 16'h0,    16'h1255, "rd_1255");
      acc(1'b0, 1'b1, 32'h0000_0010, 2'b10, 16'hCD00, 16'h0,    "wr_hi");
      acc(1'b0, 1'b0, 32'h0000_0010, 2'b01, 16'h0,    16'hCD55, "rd_cd55");
      // misses: read gives FFFF, write to an alias of 0x0004 is dropped
      acc(1'b0, 1'b0, 32'h0001_0000, 2'b11, 16'h0,    16'hFFFF, "rd_miss");
      acc(1'b0, 1'b1, 32'h0001_0004, 2'b11, 16'h9999, 16'h0,    "wr_miss");
      acc(1'b0, 1'b0, 32'h0000_0004, 2'b11, 16'h0,    16'hBEEF, "rd_alias");
      // window at the top of the address space, three wait states
      acc(1'b1, 1'b1, 32'hFFFF_F800, 2'b11, 16'hA000, 16'h0,    "wr_f800");
      acc(1'b1, 1'b1, 32'hFFFF_F802, 2'b11, 16'h0B02, 16'h0,    "wr_f802");
      acc(1'b1, 1'b1, 32'hFFFF_F820, 2'b11, 16'h1111, 16'h0,    "wr_f820");
      acc(1'b1, 1'b0, 32'h0000_0000, 2'b11, 16'h0,    16'hFFFF, "rd_wrap_miss");
      acc(1'b1, 1'b0, 32'hFFFF_F820, 2'b11, 16'h0,    16'h1111, "rd_f820");
      // abort: drop cyc during WAIT, no ack and no write
      @(negedge clk);
      drive(1'b1, 1'b1, 2'b11, 1'b1, 32'hFFFF_F820, 16'h5A5A);
      @(negedge clk);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 16'h0);
      repeat (8) @(negedge clk);
      acc(1'b1, 1'b0, 32'hFFFF_F820, 2'b11, 16'h0, 16'h1111, "rd_after_abort");
      // reset on the edge that would commit the write
      @(negedge clk);
      drive(1'b1, 1'b1, 2'b11, 1'b1, 32'hFFFF_F820, 16'h7777);
      repeat (3) @(negedge clk);
      rst3 = 1'b1;
      @(negedge clk);
      compared++;
      if (b3.ack !== 1'b0 || u3.state_q !== ST_IDLE) begin
         mismatched++;
         $display("FAIL reset_mid_wait: ack %b state %0d, required 0 %0d", b3.ack, u3.state_q, ST_IDLE);
      end
      rst3 = 1'b0;
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 16'h0);
      acc(1'b1, 1'b0, 32'hFFFF_F820, 2'b11, 16'h0, 16'h1111, "rd_after_reset");
      // back-to-back reads with strobe held: period 2+3 cycles
      @(negedge clk);
      drive(1'b1, 1'b1, 2'b11, 1'b0, 32'hFFFF_F800, 16'h0);
      c = cyc_n;
      push(1'b1, 16'hA000, c + 4);
      push(1'b1, 16'h0B02, c + 9);
      wait_ack(1'b1, "b2b_first");
      b3.addr = 32'hFFFF_F802;
      wait_ack(1'b1, "b2b_second");
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 16'h0);
      repeat (6) @(negedge clk);
      compared++;
      if (q1.size() + q3.size() != 0) begin
         mismatched++;
         $display("FAIL pending: %0d acks outstanding, required 0", q1.size() + q3.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
